decim_fir_ctrl: RTL
===================

# decim_fir_ctrl

Sequencer for one decimating FIR stage of the FM receiver chain (e.g. the AUDIO_DECIM = 8 audio low-pass after demodulation). It pulls quantized samples (Q.10 fixed point, 32-bit signed) from an upstream FWFT FIFO and keeps a TAPS-deep sample history. For every DECIM samples consumed, it runs a single shared multiplier over all taps, one per cycle, and pushes one dequantized result to a downstream FIFO. Coefficients are loaded at run time through a small config port.

## Interface
- TAPS, 32: filter length (MAX_TAPS); ≥1.
- DECIM, 8: input samples consumed per output; ≥1.
- BITS, 10: quantization shift; QUANT_VAL = 1<<BITS.
- DATA_WIDTH, 32: sample/coefficient/result width, signed.

- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_empty  in  1  upstream FIFO empty.
- in_dout  in  DATA_WIDTH  upstream head word; valid same cycle when !in_empty.
- in_rd_en  out  1  pop upstream.
- out_full  in  1  downstream FIFO full.
- out_wr_en  out  1  push downstream.
- out_din  out  DATA_WIDTH  filter result.
- cfg_wr  in  1  coefficient write strobe.
- cfg_addr  in  $clog2(TAPS)  coefficient index.
- cfg_data  in  DATA_WIDTH  quantized coefficient.
- cfg_busy  out  1  high when cfg writes are ignored (state ≠ S_LOAD).

## Operation
- Storage: hist[0..TAPS-1], where hist[0] is the newest sample; coef[0..TAPS-1]; acc (32-bit); rd_cnt (0..DECIM-1); tap_cnt (0..TAPS-1).
- Function: y = Σ_{i=0}^{TAPS-1} DEQ(coef[i]·hist[i]).
  - Product: low 32 bits of the signed 32×32 product.
  - DEQ: signed divide by QUANT_VAL, truncating toward zero (not an arithmetic shift).
  - Accumulation wraps mod 2^32.
- States:
  - S_LOAD: in_rd_en = !in_empty. On each read, hist shifts up by one, hist[0] ← in_dout, rd_cnt increments. On the read where rd_cnt = DECIM-1: rd_cnt ← 0, acc ← 0, tap_cnt ← 0, go to S_MAC.
  - S_MAC: one tap per cycle, acc ← acc + DEQ(coef[tap_cnt]·hist[tap_cnt]). After tap TAPS-1, go to S_OUT.
  - S_OUT: out_din = acc; out_wr_en = !out_full. On the write cycle, go to S_LOAD. While out_full is high, hold the state and acc.
- In S_MAC and S_OUT, in_rd_en = 0 and hist is frozen.
- Config:
  - cfg_wr in S_LOAD writes coef[cfg_addr] ← cfg_data.
  - cfg_wr in any other state is dropped; cfg_busy = 1 there.
  - A cfg_addr ≥ TAPS is ignored.
- Reset clears: state ← S_LOAD; hist, coef, acc, counters ← 0; in_rd_en = out_wr_en = 0 on the reset cycle. Reset mid-MAC or mid-OUT discards the partial result, and no write is issued.

## Timing
- in_rd_en and out_wr_en are combinational from state and the FIFO flags. out_din is registered (acc).
- Latency from the DECIM-th read to out_wr_en: exactly TAPS+1 cycles when out_full = 0, i.e. TAPS MAC cycles plus one S_OUT cycle.
- Peak rate with no stalls: one output every DECIM+TAPS+1 cycles (41 at the defaults).
- In S_LOAD, in_empty high stalls the stage with no read and no state change. Reads need not be consecutive; exactly DECIM reads happen per output.
- In S_OUT, out_full high stalls indefinitely; out_din stays stable and no input is consumed.
- The first output uses zero-initialised history, with no priming phase.
- A write to coef[k] in the same cycle as the final read of a batch takes effect for that batch, because MAC starts on the next cycle.

## Test plan
- Reset/zero: coefs at the reset value 0; feed 8 samples of 5000 → one write, out_din = 0; out_wr_en and in_rd_en are 0 during reset.
- DC gain: all 32 coefs = 32; constant input 1024 → every output = 1024 (32 × DEQ(32768) = 32 × 32).
- Impulse/ordering: coef[k] = k·1024; input 1024 then zeros → outputs 7168, 15360, 23552, 31744, then 0.
- Truncation sign: coef[0] = 1, other coefs 0; 7 zeros then −1 → out 0. Repeat with −1025 as the last sample → out −1. Repeat with +2047 → out 1.
- Flow control:
  - Random in_empty toggling yields exactly 8 pops per output.
  - out_full held 5 cycles in S_OUT → out_wr_en = 0 and in_rd_en = 0 throughout; a single write of the unchanged value on release.
  - TAPS+1 cycles from the 8th pop to the write.
- Config/reset:
  - cfg_wr during S_MAC is ignored (cfg_busy = 1) and the output is unchanged; the same write in S_LOAD changes the next output.
  - reset asserted mid-S_MAC → no write; the next batch starts from zero history.

Source files
------------

// File: rtl/decim_fir_ctrl.sv
// Decimating FIR sequencer: pulls DECIM samples from an upstream FWFT FIFO,
// then runs one shared multiplier across all TAPS taps (one per cycle) and
// pushes the dequantized sum to a downstream FIFO. Coefficients are written
// through a small config port, accepted only while loading samples.
module decim_fir_ctrl #(
    parameter int TAPS       = 32,
    parameter int DECIM      = 8,
    parameter int BITS       = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        in_empty,
    input  logic [DATA_WIDTH-1:0]                       in_dout,
    output logic                                        in_rd_en,
    input  logic                                        out_full,
    output logic                                        out_wr_en,
    output logic [DATA_WIDTH-1:0]                       out_din,
    input  logic                                        cfg_wr,
    input  logic [((TAPS > 1) ? $clog2(TAPS) : 1)-1:0]  cfg_addr,
    input  logic [DATA_WIDTH-1:0]                       cfg_data,
    output logic                                        cfg_busy
);

    localparam int AW = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
    localparam logic [CW-1:0] LAST_RD  = CW'(DECIM - 1);
    // Adding QUANT_VAL-1 to negative products before the arithmetic shift
    // turns floor division into truncation toward zero.
    localparam logic signed [DATA_WIDTH-1:0] DEQ_BIAS = DATA_WIDTH'((1 << BITS) - 1);
    localparam bit ADDR_ALL_VALID = (TAPS == (1 << AW));

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CW-1:0]                 rd_cnt_q, rd_cnt_d;
    logic [AW-1:0]                 tap_cnt_q, tap_cnt_d;
    logic signed [DATA_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]  hist_q [TAPS];
    logic signed [DATA_WIDTH-1:0]  coef_q [TAPS];
    logic signed [DATA_WIDTH-1:0]  prod;
    logic                          addr_ok;

    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [DATA_WIDTH-1:0] p);
        logic signed [DATA_WIDTH-1:0] bias;
        bias = p[DATA_WIDTH-1] ? DEQ_BIAS : '0;
        return (p + bias) >>> BITS;
    endfunction

    assign out_din  = acc_q;
    assign cfg_busy = (state_q != S_LOAD);
    assign addr_ok  = ADDR_ALL_VALID || ({{(32-AW){1'b0}}, cfg_addr} < 32'(TAPS));

    // Next-state, counters, accumulator and FIFO handshakes.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        tap_cnt_d = tap_cnt_q;
        acc_d     = acc_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;
        prod      = coef_q[tap_cnt_q] * hist_q[tap_cnt_q];
        unique case (state_q)
            S_LOAD: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    if (rd_cnt_q == LAST_RD) begin
                        rd_cnt_d  = '0;
                        acc_d     = '0;
                        tap_cnt_d = '0;
                        state_d   = S_MAC;
                    end else begin
                        rd_cnt_d = rd_cnt_q + CW'(1);
                    end
                end
            end
            S_MAC: begin
                acc_d = acc_q + deq(prod);
                if (tap_cnt_q == LAST_TAP) begin
                    state_d = S_OUT;
                end else begin
                    tap_cnt_d = tap_cnt_q + AW'(1);
                end
            end
            S_OUT: begin
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
        // No FIFO traffic on a reset cycle, whatever state was left behind.
        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    // State, counters and accumulator registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_LOAD;
            rd_cnt_q  <= '0;
            tap_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            tap_cnt_q <= tap_cnt_d;
            acc_q     <= acc_d;
        end
    end

    // Sample history: shifts toward older entries on every pop, newest in slot 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
        end else if (in_rd_en) begin
            for (int i = TAPS - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= $signed(in_dout);
        end
    end

    // Coefficient bank: writable only while loading, so MAC never sees a change mid-sum.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) coef_q[i] <= '0;
        end else if (cfg_wr && (state_q == S_LOAD) && addr_ok) begin
            coef_q[cfg_addr] <= $signed(cfg_data);
        end
    end

endmodule
